// File: rtl/implication_checker.sv
// rtl/implication_checker.sv - multi-lane implication recorder with conflict detection and level sweep
//
// Purpose:
//   Records up to LANES implications per cycle into a per-variable table of
//   {assigned, val, level}. Reports conflicts against the table and between
//   lanes of the same batch. Forwards new, non-duplicate assignments one cycle
//   later. Backtracking clears every entry above a level with a multi-cycle sweep.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_imp_valid      per-lane implication valid
//   i_imp_var        per-lane variable index, lane i at [i*VAR_W +: VAR_W]
//   i_imp_val        per-lane implied value
//   i_cur_level      decision level stamped on accepted assignments
//   o_in_ready       batch accepted when any i_imp_valid bit is set and this is high
//   i_bt_valid       backtrack request
//   i_bt_level       clear every assignment whose level is greater than this
//   o_bt_done        one-cycle pulse in the last sweep cycle
//   o_conflict       sticky conflict flag
//   o_conflict_var   variable of the lowest conflicting lane
//   o_out_valid      per-lane forward valid (registered, one cycle)
//   o_out_var        forwarded indices
//   o_out_val        forwarded values
module implication_checker #(
  parameter int VAR_COUNT       = 512,
  parameter int VAR_W           = $clog2(VAR_COUNT),
  parameter int LANES           = 2,
  parameter int LEVEL_W         = 9,
  parameter int SWEEP_PER_CYCLE = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [LANES-1:0]         i_imp_valid,
  input  logic [LANES*VAR_W-1:0]   i_imp_var,
  input  logic [LANES-1:0]         i_imp_val,
  input  logic [LEVEL_W-1:0]       i_cur_level,
  output logic                     o_in_ready,
  input  logic                     i_bt_valid,
  input  logic [LEVEL_W-1:0]       i_bt_level,
  output logic                     o_bt_done,
  output logic                     o_conflict,
  output logic [VAR_W-1:0]         o_conflict_var,
  output logic [LANES-1:0]         o_out_valid,
  output logic [LANES*VAR_W-1:0]   o_out_var,
  output logic [LANES-1:0]         o_out_val
);

  localparam int LAST_PTR = VAR_COUNT - SWEEP_PER_CYCLE;

  typedef enum logic [1:0] {ACTIVE, CONFLICT, SWEEP} state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic                   r_assigned [VAR_COUNT];
  logic                   r_val      [VAR_COUNT];
  logic [LEVEL_W-1:0]     r_level    [VAR_COUNT];

  logic [LEVEL_W-1:0]     r_bt_level;
  logic [VAR_W-1:0]       r_ptr;
  logic [VAR_W-1:0]       w_ptr_next;
  logic                   r_conflict;
  logic [VAR_W-1:0]       r_conflict_var;
  logic                   r_bt_done;
  logic                   w_bt_done_next;
  logic [LANES-1:0]       r_out_valid;
  logic [LANES*VAR_W-1:0] r_out_var;
  logic [LANES-1:0]       r_out_val;

  logic [VAR_W-1:0]       w_var [LANES];
  logic [LANES-1:0]       w_lane_opp;
  logic [LANES-1:0]       w_lane_same;
  logic [LANES-1:0]       w_conf;
  logic [LANES-1:0]       w_new;
  logic                   w_any_conf;
  logic [VAR_W-1:0]       w_conf_var;
  logic                   w_bt_accept;
  logic                   w_batch_accept;
  logic                   w_commit;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_var[i] = i_imp_var[i*VAR_W +: VAR_W];
    end
  end

  // Intra-batch comparison: each lane only looks at valid lanes below it, so
  // the lowest lane of a same-var group is the one that may become New.
  always_comb begin
    w_lane_opp  = '0;
    w_lane_same = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < i; j++) begin
        if (i_imp_valid[j] && (w_var[j] == w_var[i])) begin
          if (i_imp_val[j] != i_imp_val[i]) begin
            w_lane_opp[i] = 1'b1;
          end else begin
            w_lane_same[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_conf     = '0;
    w_new      = '0;
    w_conf_var = '0;
    for (int i = 0; i < LANES; i++) begin
      w_conf[i] = i_imp_valid[i] &&
                  ((r_assigned[w_var[i]] && (r_val[w_var[i]] != i_imp_val[i])) || w_lane_opp[i]);
      w_new[i]  = i_imp_valid[i] && !w_conf[i] && !r_assigned[w_var[i]] && !w_lane_same[i];
    end
    // Walk downward so the lowest conflicting lane wins.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_conf[i]) begin
        w_conf_var = w_var[i];
      end
    end
  end

  assign w_any_conf = |w_conf;

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_bt_accept    = 1'b0;
    w_batch_accept = 1'b0;
    case (r_state)
      ACTIVE: begin
        if (i_bt_valid) begin
          w_bt_accept  = 1'b1;
          w_state_next = SWEEP;
          w_ptr_next   = '0;
        end else if (|i_imp_valid) begin
          w_batch_accept = 1'b1;
          if (w_any_conf) begin
            w_state_next = CONFLICT;
          end
        end
      end
      CONFLICT: begin
        if (i_bt_valid) begin
          w_bt_accept  = 1'b1;
          w_state_next = SWEEP;
          w_ptr_next   = '0;
        end
      end
      SWEEP: begin
        if (r_ptr == VAR_W'(LAST_PTR)) begin
          w_state_next = ACTIVE;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + VAR_W'(SWEEP_PER_CYCLE);
        end
      end
      default: begin
        w_state_next = ACTIVE;
        w_ptr_next   = '0;
      end
    endcase
  end

  assign w_commit = w_batch_accept && !w_any_conf;

  // Registered so the pulse lands in the cycle that sweeps the last group.
  assign w_bt_done_next = (w_state_next == SWEEP) && (w_ptr_next == VAR_W'(LAST_PTR));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ACTIVE;
      r_ptr          <= '0;
      r_bt_level     <= '0;
      r_conflict     <= 1'b0;
      r_conflict_var <= '0;
      r_bt_done      <= 1'b0;
      r_out_valid    <= '0;
      r_out_var      <= '0;
      r_out_val      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_bt_done <= w_bt_done_next;
      if (w_bt_accept) begin
        r_bt_level <= i_bt_level;
        r_conflict <= 1'b0;
      end else if (w_batch_accept && w_any_conf) begin
        r_conflict     <= 1'b1;
        r_conflict_var <= w_conf_var;
      end
      r_out_valid <= w_commit ? w_new : '0;
      if (w_commit) begin
        r_out_var <= i_imp_var;
        r_out_val <= i_imp_val;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < VAR_COUNT; k++) begin
        r_assigned[k] <= 1'b0;
      end
    end else if (r_state == SWEEP) begin
      for (int k = 0; k < SWEEP_PER_CYCLE; k++) begin
        if (r_level[r_ptr + VAR_W'(k)] > r_bt_level) begin
          r_assigned[r_ptr + VAR_W'(k)] <= 1'b0;
        end
      end
    end else if (w_commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_new[i]) begin
          r_assigned[w_var[i]] <= 1'b1;
        end
      end
    end
  end

  // Value and level are only meaningful while assigned is set, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_new[i]) begin
          r_val[w_var[i]]   <= i_imp_val[i];
          r_level[w_var[i]] <= i_cur_level;
        end
      end
    end
  end

  assign o_in_ready     = (r_state == ACTIVE) && !i_bt_valid;
  assign o_bt_done      = r_bt_done;
  assign o_conflict     = r_conflict;
  assign o_conflict_var = r_conflict_var;
  assign o_out_valid    = r_out_valid;
  assign o_out_var      = r_out_var;
  assign o_out_val      = r_out_val;

endmodule

// File: tb/tb_implication_checker.sv
// tb/tb_implication_checker.sv - scoreboard bench for implication_checker
module tb_implication_checker;
  localparam int VAR_COUNT = 512;
  localparam int VAR_W     = 9;
  localparam int LANES     = 2;
  localparam int LEVEL_W   = 9;
  localparam int SPC       = 8;
  localparam int GROUPS    = VAR_COUNT / SPC;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [LANES-1:0]       i_imp_valid;
  logic [LANES*VAR_W-1:0] i_imp_var;
  logic [LANES-1:0]       i_imp_val;
  logic [LEVEL_W-1:0]     i_cur_level;
  logic                   o_in_ready;
  logic                   i_bt_valid;
  logic [LEVEL_W-1:0]     i_bt_level;
  logic                   o_bt_done;
  logic                   o_conflict;
  logic [VAR_W-1:0]       o_conflict_var;
  logic [LANES-1:0]       o_out_valid;
  logic [LANES*VAR_W-1:0] o_out_var;
  logic [LANES-1:0]       o_out_val;

  always #5 clk = ~clk;

  implication_checker #(
    .VAR_COUNT(VAR_COUNT), .VAR_W(VAR_W), .LANES(LANES),
    .LEVEL_W(LEVEL_W), .SWEEP_PER_CYCLE(SPC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_imp_valid(i_imp_valid), .i_imp_var(i_imp_var), .i_imp_val(i_imp_val),
    .i_cur_level(i_cur_level), .o_in_ready(o_in_ready),
    .i_bt_valid(i_bt_valid), .i_bt_level(i_bt_level), .o_bt_done(o_bt_done),
    .o_conflict(o_conflict), .o_conflict_var(o_conflict_var),
    .o_out_valid(o_out_valid), .o_out_var(o_out_var), .o_out_val(o_out_val)
  );

  typedef struct {
    int         cyc;
    logic [1:0] mask;
    int         idx0;
    bit         val0;
    int         idx1;
    bit         val1;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Reference model state
  bit   m_asg [VAR_COUNT];
  bit   m_val [VAR_COUNT];
  int   m_lvl [VAR_COUNT];
  bit   m_conflict;
  int   m_cvar;
  bit   m_sweeping;
  int   m_done;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < VAR_COUNT; k++) begin
      m_asg[k] = 1'b0;
      m_val[k] = 1'b0;
      m_lvl[k] = 0;
    end
    m_conflict = 1'b0;
    m_cvar     = 0;
    m_sweeping = 1'b0;
    m_done     = 0;
    sb_q.delete();
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT forwards.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cycle) begin
          check("fwd_missing", 0, sb_q[0].mask);
          void'(sb_q.pop_front());
        end
        if (o_out_valid != 2'b00) begin
          if (sb_q.size() == 0) begin
            check("fwd_unexpected", o_out_valid, 0);
          end else begin
            e = sb_q.pop_front();
            check("fwd_cycle", cycle, e.cyc);
            check("fwd_mask", o_out_valid, e.mask);
            if (e.mask[0]) begin
              check("fwd_var0", o_out_var[VAR_W-1:0], e.idx0);
              check("fwd_val0", o_out_val[0], e.val0);
            end
            if (e.mask[1]) begin
              check("fwd_var1", o_out_var[2*VAR_W-1:VAR_W], e.idx1);
              check("fwd_val1", o_out_val[1], e.val1);
            end
          end
        end
      end
    end
  end

  // One cycle of stimulus; starts and ends at a falling edge.
  task automatic do_cycle(input logic [1:0] v, input int a0, input bit b0,
                          input int a1, input bit b1, input int lvl,
                          input bit btv, input int btl);
    int         c;
    bit         sweep_c, rdy, tc, lopp, lsame, anyc;
    int         cv;
    logic [1:0] newm;
    int         a [2];
    bit         b [2];
    exp_t       e;
    a[0] = a0; a[1] = a1; b[0] = b0; b[1] = b1;
    i_imp_valid = v;
    i_imp_var   = {VAR_W'(a1), VAR_W'(a0)};
    i_imp_val   = {b1, b0};
    i_cur_level = LEVEL_W'(lvl);
    i_bt_valid  = btv;
    i_bt_level  = LEVEL_W'(btl);
    c = cycle;
    if (m_sweeping && c > m_done) m_sweeping = 1'b0;
    sweep_c = m_sweeping;
    rdy = !sweep_c && !m_conflict && !btv;
    #1;
    check("in_ready", o_in_ready, rdy);
    if (!sweep_c && btv) begin
      for (int k = 0; k < VAR_COUNT; k++) begin
        if (m_asg[k] && m_lvl[k] > btl) m_asg[k] = 1'b0;
      end
      m_conflict = 1'b0;
      m_sweeping = 1'b1;
      m_done     = c + GROUPS;
    end else if (rdy && v != 2'b00) begin
      anyc = 1'b0; cv = 0; newm = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          tc = m_asg[a[i]] && (m_val[a[i]] != b[i]);
          lopp = 1'b0; lsame = 1'b0;
          for (int j = 0; j < i; j++) begin
            if (v[j] && a[j] == a[i]) begin
              if (b[j] != b[i]) lopp = 1'b1;
              else lsame = 1'b1;
            end
          end
          if (tc || lopp) begin
            if (!anyc) cv = a[i];
            anyc = 1'b1;
          end else if (!m_asg[a[i]] && !lsame) begin
            newm[i] = 1'b1;
          end
        end
      end
      if (anyc) begin
        m_conflict = 1'b1;
        m_cvar     = cv;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (newm[i]) begin
            m_asg[a[i]] = 1'b1;
            m_val[a[i]] = b[i];
            m_lvl[a[i]] = lvl;
          end
        end
        if (newm != 2'b00) begin
          e.cyc = c + 1; e.mask = newm;
          e.idx0 = a0; e.val0 = b0; e.idx1 = a1; e.val1 = b1;
          sb_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("conflict", o_conflict, m_conflict);
    check("conflict_var", o_conflict_var, m_cvar);
    check("bt_done", o_bt_done, m_sweeping && (cycle == m_done));
  endtask

  task automatic idle();
    do_cycle(2'b00, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  // Issue a backtrack and run the sweep out, checking its length.
  task automatic backtrack(input int btl);
    int t, n;
    t = cycle;
    do_cycle(2'b00, 0, 1'b0, 0, 1'b0, 0, 1'b1, btl);
    n = 0;
    while (!o_bt_done && n < 200) begin
      idle();
      n++;
    end
    check("bt_done_latency", cycle - t, GROUPS);
    idle();
  endtask

  initial begin
    int t;
    logic [1:0] v;
    int a0, a1;
    model_reset();
    rst_n = 1'b0;
    i_imp_valid = '0; i_imp_var = '0; i_imp_val = '0; i_cur_level = '0;
    i_bt_valid = 1'b0; i_bt_level = '0;
    @(negedge clk);
    check("rst_conflict", o_conflict, 0);
    check("rst_conflict_var", o_conflict_var, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_var", o_out_var, 0);
    check("rst_bt_done", o_bt_done, 0);
    check("rst_in_ready", o_in_ready, 1);
    i_bt_valid = 1'b1;
    #1;
    check("rst_in_ready_bt", o_in_ready, 0);
    i_bt_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic two-lane forward, duplicate replay, table conflict
    do_cycle(2'b11, 5, 1'b1, 9, 1'b0, 1, 1'b0, 0);
    idle();
    do_cycle(2'b01, 5, 1'b1, 0, 1'b0, 1, 1'b0, 0);
    do_cycle(2'b11, 5, 1'b0, 7, 1'b1, 1, 1'b0, 0);
    do_cycle(2'b11, 8, 1'b1, 7, 1'b1, 1, 1'b0, 0);
    idle();
    backtrack(0);

    // Intra-batch conflict, then intra-batch duplicate
    do_cycle(2'b11, 3, 1'b1, 3, 1'b0, 1, 1'b0, 0);
    idle();
    backtrack(0);
    do_cycle(2'b11, 3, 1'b1, 3, 1'b1, 1, 1'b0, 0);
    do_cycle(2'b11, 3, 1'b1, 7, 1'b1, 1, 1'b0, 0);

    // Level-based clearing
    backtrack(0);
    do_cycle(2'b01, 2, 1'b1, 0, 1'b0, 0, 1'b0, 0);
    do_cycle(2'b10, 0, 1'b0, 4, 1'b1, 2, 1'b0, 0);
    do_cycle(2'b01, 6, 1'b1, 0, 1'b0, 3, 1'b0, 0);
    backtrack(2);
    do_cycle(2'b01, 6, 1'b0, 0, 1'b0, 2, 1'b0, 0);
    do_cycle(2'b11, 4, 1'b0, 2, 1'b0, 2, 1'b0, 0);
    backtrack(2);
    do_cycle(2'b10, 0, 1'b0, 2, 1'b0, 2, 1'b0, 0);
    backtrack(0);

    // Backtrack wins over a same-cycle batch; backtrack during sweep ignored
    t = cycle;
    do_cycle(2'b11, 11, 1'b1, 12, 1'b0, 1, 1'b1, 0);
    do_cycle(2'b01, 13, 1'b1, 0, 1'b0, 1, 1'b1, 0);
    while (!o_bt_done && (cycle - t) < 200) idle();
    check("bt_ignore_latency", cycle - t, GROUPS);
    idle();

    // Reset in the middle of a sweep
    do_cycle(2'b01, 20, 1'b1, 0, 1'b0, 4, 1'b0, 0);
    do_cycle(2'b00, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1);
    repeat (9) idle();
    i_imp_valid = '0; i_bt_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_conflict", o_conflict, 0);
    check("mid_rst_out_valid", o_out_valid, 0);
    check("mid_rst_bt_done", o_bt_done, 0);
    check("mid_rst_in_ready", o_in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(2'b11, 2, 1'b1, 20, 1'b1, 0, 1'b0, 0);
    idle();

    // Randomized phase
    for (int n = 0; n < 1500; n++) begin
      v  = 2'($urandom_range(0, 3));
      a0 = $urandom_range(0, 15);
      a1 = ($urandom_range(0, 2) == 0) ? a0 : $urandom_range(0, 15);
      do_cycle(v, a0, 1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)),
               $urandom_range(0, 5),
               m_conflict ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0),
               $urandom_range(0, 5));
    end
    t = 0;
    while ((m_sweeping || m_conflict) && t < 200) begin
      if (m_conflict && !m_sweeping) do_cycle(2'b00, 0, 1'b0, 0, 1'b0, 0, 1'b1, 0);
      else idle();
      if (m_sweeping && cycle > m_done) m_sweeping = 1'b0;
      t++;
    end
    repeat (3) idle();
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/implication_checker.md
# implication_checker

Parametrised, multi-lane successor of the single-lane conflict detector in the DPLL solver datapath. It accepts up to LANES implications per cycle from the clause evaluators and records each assignment with its decision level. It reports conflicts against prior assignments and against other lanes in the same batch, and forwards new, non-duplicate assignments to the imply stack. It also performs level-based backtrack clearing with a multi-cycle sweep.

## Interface
- VAR_COUNT, 512, number of variables tracked
- VAR_W, $clog2(VAR_COUNT), variable index width
- LANES, 2, implications accepted per cycle
- LEVEL_W, 9, decision-level width
- SWEEP_PER_CYCLE, 8, entries cleared per sweep cycle; must divide VAR_COUNT
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imp_valid  in  LANES  per-lane implication valid
- imp_var  in  LANES*VAR_W  per-lane variable index; lane i at bits [i*VAR_W +: VAR_W]
- imp_val  in  LANES  per-lane implied value
- cur_level  in  LEVEL_W  decision level stamped on accepted assignments
- in_ready  out  1  batch accepted when any imp_valid bit is set and in_ready=1
- bt_valid  in  1  backtrack request
- bt_level  in  LEVEL_W  clear every assignment whose level is greater than this value
- bt_done  out  1  one-cycle pulse when the sweep completes
- conflict  out  1  sticky conflict flag
- conflict_var  out  VAR_W  variable index of the reported conflict
- out_valid  out  LANES  per-lane forward to imply stack
- out_var  out  LANES*VAR_W  forwarded index
- out_val  out  LANES  forwarded value

## Operation
- Table: per-variable {assigned, val, level[LEVEL_W]}, held in flops.
- FSM states: ACTIVE, CONFLICT, SWEEP. Reset state is ACTIVE.
- in_ready = (state==ACTIVE) && !bt_valid.
- Per-lane classification for an accepted batch, lane i with valid=1:
  - Table conflict: assigned[var] && val[var] != imp_val.
  - Lane conflict: a lower lane j<i is valid with the same var and the opposite value.
  - Duplicate: assigned with the same value, or a lower lane has the same var and the same value. Duplicates are dropped silently.
  - New: anything else.
- Any conflict in the batch:
  - The batch is atomic: no table writes and no out_valid bits.
  - conflict_var = the var of the lowest-index conflicting lane.
  - The FSM enters CONFLICT.
- No conflict in the batch: every New lane writes {1, val, cur_level} and asserts its out_valid bit with its var/val.
- CONFLICT: conflict stays high and conflict_var holds. Only bt_valid is honoured.
- bt_valid in ACTIVE or CONFLICT:
  - Latch bt_level, clear conflict, enter SWEEP with ptr=0.
  - In the same cycle as acceptance, bt_valid takes precedence over imp_valid.
- SWEEP:
  - Each cycle, entries ptr..ptr+SWEEP_PER_CYCLE-1 with level > bt_level get assigned<=0.
  - ptr advances by SWEEP_PER_CYCLE.
  - After the last group, pulse bt_done and return to ACTIVE.
  - bt_valid during SWEEP is ignored.
- Level arithmetic is unsigned. Level 0 assignments survive any backtrack.

## Timing
- Reset values (asynchronous):
  - every table entry has assigned=0;
  - state=ACTIVE, conflict=0, conflict_var=0;
  - out_valid=0, out_var=0, out_val=0;
  - bt_done=0, ptr=0.
  - in_ready therefore equals !bt_valid.
- Forward latency: 1 cycle. out_* is registered in the cycle after acceptance and is valid for that cycle only; out_valid=0 otherwise.
- The table write is visible to the next batch. Back-to-back batches touching the same var are checked correctly.
- conflict rises the cycle after the conflicting batch is accepted. in_ready is low from that cycle on.
- Backtrack: with bt_valid accepted in cycle t:
  - in_ready=0 from t+1 through the bt_done cycle;
  - conflict=0 from t+1;
  - bt_done pulses at cycle t + VAR_COUNT/SWEEP_PER_CYCLE;
  - in_ready returns to 1 in the cycle after bt_done.
- Assertion of reset mid-sweep aborts the sweep and clears the whole table.
- No backpressure from the imply stack: it must sink LANES entries per cycle.

## Test plan
- Reset, then lane0 = var 5 val 1, lane1 = var 9 val 0 at level 1 -> next cycle out_valid=2'b11 with (5,1) and (9,0); conflict=0.
- Replay var 5 val 1 -> no out_valid, no conflict. Then var 5 val 0 -> conflict=1, conflict_var=5, in_ready=0, and lane1 = var 7 in the same batch is not written or forwarded.
- Single batch with lane0 = var 3 val 1 and lane1 = var 3 val 0 -> conflict_var=3, no writes. Same batch with both lanes val 1 -> only lane0 forwarded.
- Assign var 2 at level 0, var 4 at level 2, var 6 at level 3. Then bt_level=2 -> bt_done after 64 cycles (defaults). Then var 6 val 0 forwards; var 4 val 0 and var 2 val 0 conflict.
- bt_valid asserted together with imp_valid in ACTIVE -> implication not accepted, no out_valid, sweep starts; bt_valid during SWEEP is ignored.
- Assert reset at sweep cycle 10 -> all outputs return to reset values, table empty, in_ready=1 after deassertion; the previously assigned var re-forwards when re-implied.
